// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch path: next PC from increment, jump, label branch or halt.
// Latency: one PC per cycle sequentially; a jump or taken branch costs one bubble cycle (pc_valid=0).
// Backpressure: stall=1 freezes pc in RUN and drops (does not queue) control events; the source holds them.
//
// Optional feature macro: BRANCH_STATS_EN adds taken_cnt (saturating count of accepted jumps/taken branches).
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   start, start_addr               begin execution at start_addr (accepted in IDLE and HALT)
//   stall                           hold the PC while running
//   jump_en, jump_addr              absolute jump
//   branch_en, branch_taken, lbl_idx  conditional branch through the label table
//   halt_req                        stop fetching
//   lbl_wr_en, lbl_wr_idx, lbl_wr_data  label-table write port
//   pc, pc_valid                    fetch address and its qualifier
//   redirect                        pulse coincident with a non-sequential pc load
//   halted                          sequencer is in HALT
//   taken_cnt                       (BRANCH_STATS_EN only) redirect statistics
module pc_sequencer #(
   parameter int PC_W      = 16,
   parameter int LBL_DEPTH = 16,
   parameter int LBL_IDX_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [PC_W-1:0]      start_addr,
   input  logic                 stall,
   input  logic                 jump_en,
   input  logic [PC_W-1:0]      jump_addr,
   input  logic                 branch_en,
   input  logic                 branch_taken,
   input  logic [LBL_IDX_W-1:0] lbl_idx,
   input  logic                 halt_req,
   input  logic                 lbl_wr_en,
   input  logic [LBL_IDX_W-1:0] lbl_wr_idx,
   input  logic [PC_W-1:0]      lbl_wr_data,
   output logic [PC_W-1:0]      pc,
   output logic                 pc_valid,
   output logic                 redirect,
`ifdef BRANCH_STATS_EN
   output logic [15:0]          taken_cnt,
`endif
   output logic                 halted
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_BUBBLE = 2'd2,
      S_HALT   = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_nxt_state;
   logic [PC_W-1:0]  r_pc;
   logic [PC_W-1:0]  w_nxt_pc;
   logic             r_redirect;
   logic             w_nxt_redirect;
   logic [PC_W-1:0]  r_lbl [LBL_DEPTH];
`ifdef BRANCH_STATS_EN
   logic             w_start_acc;
   logic             w_taken_acc;
   logic [15:0]      r_taken_cnt;
`endif

   // State, PC and redirect registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_redirect <= 1'b0;
      end else begin
         r_state    <= w_nxt_state;
         r_pc       <= w_nxt_pc;
         r_redirect <= w_nxt_redirect;
      end
   end

   // Next-state / next-PC selection
   always_comb begin
      w_nxt_state    = r_state;
      w_nxt_pc       = r_pc;
      w_nxt_redirect = 1'b0;
`ifdef BRANCH_STATS_EN
      w_start_acc    = 1'b0;
      w_taken_acc    = 1'b0;
`endif
      case (r_state)
         S_IDLE, S_HALT: begin
            if (start) begin
               w_nxt_pc    = start_addr;
               w_nxt_state = S_RUN;
`ifdef BRANCH_STATS_EN
               w_start_acc = 1'b1;
`endif
            end
         end
         S_RUN: begin
            if (!stall) begin
               if (halt_req) begin
                  w_nxt_state = S_HALT;
               end else if (jump_en) begin
                  w_nxt_pc       = jump_addr;
                  w_nxt_redirect = 1'b1;
                  w_nxt_state    = S_BUBBLE;
`ifdef BRANCH_STATS_EN
                  w_taken_acc    = 1'b1;
`endif
               end else if (branch_en && branch_taken) begin
                  // Read happens before this cycle's table write lands: old entry wins.
                  w_nxt_pc       = r_lbl[lbl_idx];
                  w_nxt_redirect = 1'b1;
                  w_nxt_state    = S_BUBBLE;
`ifdef BRANCH_STATS_EN
                  w_taken_acc    = 1'b1;
`endif
               end else begin
                  w_nxt_pc = r_pc + 1'b1;   // wraps silently at 2^PC_W
               end
            end
         end
         S_BUBBLE: begin
            w_nxt_state = S_RUN;            // pc already holds the redirect target
         end
         default: begin
            w_nxt_state = S_IDLE;
         end
      endcase
   end

   // Label table: written in any state, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LBL_DEPTH; i++) begin
            r_lbl[i] <= '0;
         end
      end else if (lbl_wr_en) begin
         r_lbl[lbl_wr_idx] <= lbl_wr_data;
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_taken_cnt <= '0;
      end else if (w_start_acc) begin
         r_taken_cnt <= '0;
      end else if (w_taken_acc && (r_taken_cnt != 16'hFFFF)) begin
         r_taken_cnt <= r_taken_cnt + 16'd1;
      end
   end

   assign taken_cnt = r_taken_cnt;
`endif

   assign pc       = r_pc;
   assign redirect = r_redirect;
   assign pc_valid = (r_state == S_RUN);
   assign halted   = (r_state == S_HALT);

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter controller for the instruction-fetch path.
- Owns the jump-label table, which maps a 4-bit label index to a PC_W-bit target.
- Each cycle it picks the next PC from one of: sequential increment, absolute jump, label-table branch, or halt.
- Inserts a one-cycle fetch bubble on every redirect and stalls on request from the downstream pipeline.

Parameters:
- PC_W, 16, width of PC, start address, jump address and label entries.
- LBL_DEPTH, 16, number of label-table entries.
- LBL_IDX_W, 4, label index width; must equal clog2(LBL_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins execution at start_addr.
- start_addr  in  PC_W  initial PC, sampled when start is accepted.
- stall  in  1  hold the PC; no control event is accepted while high.
- jump_en  in  1  absolute jump to jump_addr.
- jump_addr  in  PC_W  absolute jump target.
- branch_en  in  1  conditional-branch instruction is present.
- branch_taken  in  1  branch condition result; qualified by branch_en.
- lbl_idx  in  LBL_IDX_W  label-table index for the branch target.
- halt_req  in  1  stop fetching.
- lbl_wr_en  in  1  label-table write strobe.
- lbl_wr_idx  in  LBL_IDX_W  label-table write index.
- lbl_wr_data  in  PC_W  label-table write data.
- pc  out  PC_W  current fetch address.
- pc_valid  out  1  pc is a valid fetch address this cycle.
- redirect  out  1  one-cycle pulse in the cycle the PC is loaded non-sequentially.
- halted  out  1  sequencer is in HALT.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; pc=0, pc_valid=0, redirect=0, halted=0.
  - All label entries cleared to 0.
- States: IDLE, RUN, BUBBLE, HALT.
- IDLE:
  - pc_valid=0.
  - start=1 → pc<=start_addr, go RUN. pc_valid rises the next cycle.
  - Every other input is ignored.
- RUN, pc_valid=1:
  - If stall=1: pc holds and all events are ignored. They are not queued; the source must hold them.
  - If stall=0, priority is halt_req > jump_en > (branch_en & branch_taken) > increment.
  - halt_req: pc holds; go HALT.
  - jump_en: pc<=jump_addr; redirect=1; go BUBBLE.
  - branch taken: pc<=label[lbl_idx]; redirect=1; go BUBBLE.
  - branch_en with branch_taken=0: same as increment; no redirect.
  - Increment: pc<=pc+1, modulo 2^PC_W, so 0xFFFF wraps to 0x0000 with no flag.
  - start is ignored in RUN.
- BUBBLE:
  - pc_valid=0 for exactly one cycle, then RUN.
  - pc holds the redirect target.
  - stall, jump, branch and halt are ignored in BUBBLE.
- HALT:
  - halted=1, pc_valid=0, pc holds its last value.
  - start=1 → pc<=start_addr; halted clears; go RUN.
- Registered outputs: redirect is asserted in the cycle after the qualifying input, coincident with the new pc value.
- Label table:
  - Synchronous write on lbl_wr_en, accepted in every state.
  - The branch read is combinational from the stored array.
  - Write and branch to the same index in the same cycle: the branch uses the old entry; the new value is visible from the next cycle.
- Latencies:
  - Sequential fetch: one PC per cycle.
  - Taken branch or jump: one bubble cycle.
- Reset asserted mid-operation: immediate return to IDLE with all reset values, including the label table.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds output taken_cnt[15:0]: count of accepted taken branches and jumps, saturating at 0xFFFF.
  - Cleared by reset and by an accepted start.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then start with start_addr=0x0009 → pc 9, 10, 11 on consecutive cycles; pc_valid=1 from the cycle after start.
- Write label[2]=0x004C, then branch_en=1, branch_taken=1, lbl_idx=2 → redirect=1 with pc=0x004C; pc_valid=0 for one cycle; then pc 0x004D.
- jump_en=1, jump_addr=0x0083, branch_en=1, branch_taken=1, halt_req=1 all in one cycle → HALT, pc unchanged, halted=1. Repeat without halt_req → pc=0x0083 (jump wins over branch).
- stall=1 for 3 cycles with jump_en held → pc frozen. Release stall → jump taken on the first unstalled cycle.
- Start at 0xFFFE → pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Write label[5]=0x0025 and branch to idx 5 in the same cycle → target is the old value (0 after reset). Next branch to idx 5 → 0x0025.
- rst_n low during BUBBLE → IDLE, pc=0, label table cleared.
